cache_page_writer: RTL and testbench
====================================

// Module: cache_page_writer
// PURPOSE
//  Write side of the cache fill path; the responder to the cache controller's buffer-write handshake.
//  - On cache_buffer_we, captures one 4096-bit DDR page and its page number.
//  - Serialises the page into 128 32-bit word writes on the cache RAM port.
//  - Returns cache_buffer_write_end so the controller leaves its write-to-cache state.
// PARAMETERS
//  LINE_W   4096  page width in bits
//  WORD_W   32    cache RAM word width
//  ADDR_W   32    page-number width
//  WORDS    LINE_W/WORD_W (128)  words per page
//  IDX_W    $clog2(WORDS) (7)    word-index width
// PORTS
//  clk                     in   1       single clock, rising edge
//  reset                   in   1       synchronous, active-low reset
//  cache_buffer_we         in   1       level request from controller; held high until write_end seen
//  page_addr               in   ADDR_W  page number, valid while cache_buffer_we high
//  page_data               in   LINE_W  page contents, valid while cache_buffer_we high
//  cache_we                out  1       cache RAM word write strobe
//  cache_wpage             out  ADDR_W  page number of current write
//  cache_widx              out  IDX_W   word index within page
//  cache_wdata             out  WORD_W  word data = page[WORD_W*idx +: WORD_W]
//  cache_buffer_write_end  out  1       transfer complete
//  busy                    out  1       state != IDLE
// BEHAVIOUR
//  Reset (reset==0 at posedge)
//  - state=IDLE, idx=0, shadow page/addr=0.
//  - All outputs 0; applies mid-transfer, and the partial page is abandoned.
//  States
//  - IDLE: cache_buffer_we==1 at edge E0 -> capture page_data/page_addr into shadow regs, idx=0, go WRITE.
//  - WRITE: cache_we=1 every cycle; idx++ per edge; at idx==WORDS-1 -> DONE (idx wraps to 0).
//  - DONE: cache_buffer_write_end=1.
//      - cache_buffer_we==0 at edge -> IDLE.
//      - otherwise stay DONE; never relaunches on a still-high request.
//  Timing and data
//  - Outputs are decoded from state and idx; writes come from shadow regs only.
//  - Input data may change after E0 without effect.
//  - Latency: first cache_we in the cycle after E0; last write 128 cycles after E0.
//  - write_end first high 129 cycles after E0.
//  Boundaries
//  - Request dropping during WRITE: the transfer still completes and write_end is still raised.
//  - DONE with request already low: write_end high for exactly 1 cycle, then IDLE.
//  - New request is accepted only from IDLE, so at least one idle cycle separates pages.
//  - idx counts modulo WORDS; there is no off-by-one write of word 128.
// CONFIGURATION
//  Macro CACHE_WR_READY_EN
//  - Defined: adds input cache_wready (1 bit).
//      - In WRITE, idx advances and the DONE transition happens only on edges with cache_we&&cache_wready.
//      - cache_we/wdata/widx are held stable while stalled.
//      - Latency is 128 accepted writes + 1.
//  - Undefined: port absent; every WRITE cycle counts as accepted.
// STRUCTURE
//  cache_pkg
//  - LINE_W/WORD_W/WORDS/IDX_W constants.
//  - State encodings: IDLE=2'd0, WRITE=2'd1, DONE=2'd2; 2'd3 illegal -> IDLE.
//  Sub-module: page_word_select
//  - Combinational LINE_W -> WORD_W mux indexed by cache_widx.
//  - Reused by the cache read path.
// TESTING
//  1. Reset held 3 cycles, then released -> all outputs 0, busy=0.
//  2. Page word i = 32'hA5000000|i, page_addr=32'h12, we held until write_end
//     -> 128 writes, idx 0..127, data matches, wpage=0x12.
//     -> write_end high exactly 1 cycle at E0+129, then IDLE.
//  3. page_data changed to all-ones at E0+1 -> written data still equals captured page.
//  4. Request pulsed 1 cycle only -> full 128 writes; write_end high 1 cycle.
//  5. reset=0 at E0+50 -> next cycle cache_we=0, idx=0, IDLE; fresh request restarts at idx 0.
//  6. CACHE_WR_READY_EN: wready low on every odd cycle -> idx holds while low.
//     -> exactly 128 accepted writes; write_end after last acceptance+1.

Source files
------------

// File: rtl/cache_pkg.sv
// cache_pkg
//   Shared constants and state encoding for the cache fill write path.
//   LINE_W  : DDR page width in bits
//   WORD_W  : cache RAM word width
//   ADDR_W  : page-number width
//   WORDS   : words per page
//   IDX_W   : word-index width
package cache_pkg;
  localparam int LINE_W = 4096;
  localparam int WORD_W = 32;
  localparam int ADDR_W = 32;
  localparam int WORDS  = LINE_W / WORD_W;
  localparam int IDX_W  = $clog2(WORDS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;
endpackage

// File: rtl/page_word_select.sv
// page_word_select
//   Combinational word mux: returns word idx_i of a page.
//   Shared by the cache write and read paths.
// Ports:
//   line_i  in  LINE_W  page contents
//   idx_i   in  IDX_W   word index within the page
//   word_o  out WORD_W  line_i[WORD_W*idx_i +: WORD_W]
module page_word_select
  import cache_pkg::*;
(
  input  logic [LINE_W-1:0] line_i,
  input  logic [IDX_W-1:0]  idx_i,
  output logic [WORD_W-1:0] word_o
);

  // Word view of the page keeps the variable index at exactly IDX_W bits.
  logic [WORD_W-1:0] words [WORDS];

  for (genvar g = 0; g < WORDS; g++) begin : g_words
    assign words[g] = line_i[g*WORD_W +: WORD_W];
  end

  assign word_o = words[idx_i];

endmodule

// File: rtl/cache_page_writer.sv
// cache_page_writer
//   Write side of the cache fill path. On cache_buffer_we it captures a DDR
//   page and its page number into shadow registers, writes the page to the
//   cache RAM one word per accepted cycle, then raises
//   cache_buffer_write_end until the controller drops its request.
// Configuration:
//   CACHE_WR_READY_EN  when defined, adds cache_wready; a word write only
//                      counts on cycles where cache_wready is high, and the
//                      write outputs hold steady while stalled.
// Ports:
//   clk                     in   clock, rising edge
//   reset                   in   synchronous active-low reset
//   cache_buffer_we         in   level request from the cache controller
//   page_addr               in   page number (valid with request)
//   page_data               in   page contents (valid with request)
//   cache_wready            in   RAM write accept (CACHE_WR_READY_EN only)
//   cache_we                out  cache RAM word write strobe
//   cache_wpage             out  page number of the current write
//   cache_widx              out  word index within the page
//   cache_wdata             out  word data
//   cache_buffer_write_end  out  transfer complete
//   busy                    out  not idle
module cache_page_writer
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              cache_buffer_we,
  input  logic [ADDR_W-1:0] page_addr,
  input  logic [LINE_W-1:0] page_data,
`ifdef CACHE_WR_READY_EN
  input  logic              cache_wready,
`endif
  output logic              cache_we,
  output logic [ADDR_W-1:0] cache_wpage,
  output logic [IDX_W-1:0]  cache_widx,
  output logic [WORD_W-1:0] cache_wdata,
  output logic              cache_buffer_write_end,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q,   idx_d;
  logic [LINE_W-1:0] page_q,  page_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic              accept;

`ifdef CACHE_WR_READY_EN
  assign accept = cache_wready;
`else
  assign accept = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    page_d  = page_q;
    addr_d  = addr_q;
    case (state_q)
      ST_IDLE: begin
        if (cache_buffer_we) begin
          page_d  = page_data;
          addr_d  = page_addr;
          idx_d   = '0;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (accept) begin
          // Index wraps to 0 on the last word, so word WORDS is never written.
          idx_d = idx_q + 1'b1;
          if (idx_q == IDX_W'(WORDS - 1)) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // Only a dropped request returns to IDLE; a held one never relaunches.
        if (!cache_buffer_we) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      page_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      page_q  <= page_d;
      addr_q  <= addr_d;
    end
  end

  assign cache_we               = (state_q == ST_WRITE);
  assign cache_buffer_write_end = (state_q == ST_DONE);
  assign busy                   = (state_q != ST_IDLE);
  assign cache_wpage            = addr_q;
  assign cache_widx             = idx_q;

  page_word_select u_sel (
    .line_i (page_q),
    .idx_i  (idx_q),
    .word_o (cache_wdata)
  );

endmodule

// File: tb/tb_cache_page_writer.sv
module tb_cache_page_writer;
  import cache_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              cache_buffer_we;
  logic [ADDR_W-1:0] page_addr;
  logic [LINE_W-1:0] page_data;
  logic              cache_wready;
  logic              cache_we;
  logic [ADDR_W-1:0] cache_wpage;
  logic [IDX_W-1:0]  cache_widx;
  logic [WORD_W-1:0] cache_wdata;
  logic              cache_buffer_write_end;
  logic              busy;

  cache_page_writer dut (
    .clk                    (clk),
    .reset                  (reset),
    .cache_buffer_we        (cache_buffer_we),
    .page_addr              (page_addr),
    .page_data              (page_data),
`ifdef CACHE_WR_READY_EN
    .cache_wready           (cache_wready),
`endif
    .cache_we               (cache_we),
    .cache_wpage            (cache_wpage),
    .cache_widx             (cache_widx),
    .cache_wdata            (cache_wdata),
    .cache_buffer_write_end (cache_buffer_write_end),
    .busy                   (busy)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  logic [LINE_W-1:0] pageA, pageB;

  // Observations from one transfer; n counts negedges after the launch edge E0.
  int c_nwr, c_derr, c_first, c_lastacc, c_end, c_endcyc, c_stallerr;
  bit c_timeout;

  task automatic launch(input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] p);
    @(negedge clk);
    page_addr       = a;
    page_data       = p;
    cache_buffer_we = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // hold_extra < 0: request already dropped by caller; otherwise drop it after
  // write_end has been seen for hold_extra+1 cycles.
  task automatic collect(input logic [LINE_W-1:0] exp_page, input logic [ADDR_W-1:0] exp_addr,
                         input int hold_extra, input bit scramble, input bit stall_pat);
    int nw;
    bit prev_stall;
    logic [IDX_W-1:0]  prev_idx;
    logic [WORD_W-1:0] expw;
    nw = 0; prev_stall = 0; prev_idx = '0;
    c_derr = 0; c_first = -1; c_lastacc = -1; c_end = -1; c_endcyc = 0;
    c_stallerr = 0; c_timeout = 1;
    for (int n = 1; n <= 600; n++) begin
      if (stall_pat) cache_wready = (n % 2 == 0);
      @(negedge clk);
      if (scramble && n == 1) page_data = '1;
      if (cache_we) begin
        if (prev_stall && cache_widx !== prev_idx) c_stallerr++;
        if (cache_wready) begin
          expw = WORD_W'(exp_page >> (WORD_W * nw));
          if (cache_widx !== IDX_W'(nw) || cache_wdata !== expw || cache_wpage !== exp_addr)
            c_derr++;
          if (c_first < 0) c_first = n;
          c_lastacc = n;
          nw++;
        end
        prev_stall = !cache_wready;
        prev_idx   = cache_widx;
      end else begin
        prev_stall = 0;
      end
      if (cache_buffer_write_end) begin
        if (c_end < 0) c_end = n;
        c_endcyc++;
        if (hold_extra >= 0 && c_endcyc > hold_extra) cache_buffer_we = 1'b0;
      end
      if (!busy && c_endcyc > 0) begin
        c_timeout = 0;
        break;
      end
    end
    c_nwr = nw;
    cache_wready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; cache_buffer_we = 1'b0; page_addr = '0; page_data = '0; cache_wready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    total++; if (cache_we !== 1'b0) $display("FAIL rst_we got %b want 0", cache_we); else passed++;
    total++; if (cache_buffer_write_end !== 1'b0) $display("FAIL rst_end got %b want 0", cache_buffer_write_end); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else passed++;
    total++; if (cache_widx !== '0) $display("FAIL rst_idx got %0d want 0", cache_widx); else passed++;
    total++; if (cache_wdata !== '0) $display("FAIL rst_wdata got %h want 0", cache_wdata); else passed++;
    total++; if (cache_wpage !== '0) $display("FAIL rst_wpage got %h want 0", cache_wpage); else passed++;
  endtask

  task automatic test_basic();
    launch(32'h12, pageA);
    total++; if (busy !== 1'b1) $display("FAIL basic_busy got %b want 1", busy); else passed++;
    collect(pageA, 32'h12, 0, 0, 0);
    total++; if (c_timeout) $display("FAIL basic_timeout got 1 want 0"); else passed++;
    total++; if (c_nwr !== 128) $display("FAIL basic_nwrites got %0d want 128", c_nwr); else passed++;
    total++; if (c_derr !== 0) $display("FAIL basic_data_errs got %0d want 0", c_derr); else passed++;
    total++; if (c_first !== 1) $display("FAIL basic_first got %0d want 1", c_first); else passed++;
    total++; if (c_lastacc !== 128) $display("FAIL basic_last got %0d want 128", c_lastacc); else passed++;
    total++; if (c_end !== 129) $display("FAIL basic_end_at got %0d want 129", c_end); else passed++;
    total++; if (c_endcyc !== 1) $display("FAIL basic_end_cycles got %0d want 1", c_endcyc); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL basic_idle got %b want 0", busy); else passed++;
  endtask

  task automatic test_input_change();
    launch(32'h34, pageB);
    collect(pageB, 32'h34, 0, 1, 0);
    total++; if (c_nwr !== 128) $display("FAIL chg_nwrites got %0d want 128", c_nwr); else passed++;
    total++; if (c_derr !== 0) $display("FAIL chg_data_errs got %0d want 0", c_derr); else passed++;
  endtask

  task automatic test_pulse();
    launch(32'h56, pageA);
    cache_buffer_we = 1'b0;
    collect(pageA, 32'h56, -1, 0, 0);
    total++; if (c_nwr !== 128) $display("FAIL pulse_nwrites got %0d want 128", c_nwr); else passed++;
    total++; if (c_derr !== 0) $display("FAIL pulse_data_errs got %0d want 0", c_derr); else passed++;
    total++; if (c_end !== 129) $display("FAIL pulse_end_at got %0d want 129", c_end); else passed++;
    total++; if (c_endcyc !== 1) $display("FAIL pulse_end_cycles got %0d want 1", c_endcyc); else passed++;
  endtask

  task automatic test_done_hold();
    launch(32'h5a, pageB);
    collect(pageB, 32'h5a, 5, 0, 0);
    total++; if (c_endcyc !== 6) $display("FAIL hold_end_cycles got %0d want 6", c_endcyc); else passed++;
    total++; if (c_nwr !== 128) $display("FAIL hold_nwrites got %0d want 128", c_nwr); else passed++;
  endtask

  task automatic test_mid_reset();
    launch(32'h77, pageB);
    repeat (49) @(posedge clk);
    @(negedge clk);
    total++; if (cache_widx !== IDX_W'(49)) $display("FAIL mrst_pre_idx got %0d want 49", cache_widx); else passed++;
    reset = 1'b0; cache_buffer_we = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total++; if (cache_we !== 1'b0) $display("FAIL mrst_we got %b want 0", cache_we); else passed++;
    total++; if (cache_widx !== '0) $display("FAIL mrst_idx got %0d want 0", cache_widx); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL mrst_busy got %b want 0", busy); else passed++;
    total++; if (cache_wpage !== '0) $display("FAIL mrst_wpage got %h want 0", cache_wpage); else passed++;
    reset = 1'b1;
    launch(32'h99, pageA);
    collect(pageA, 32'h99, 0, 0, 0);
    total++; if (c_first !== 1) $display("FAIL mrst_restart_first got %0d want 1", c_first); else passed++;
    total++; if (c_nwr !== 128) $display("FAIL mrst_restart_nwrites got %0d want 128", c_nwr); else passed++;
    total++; if (c_derr !== 0) $display("FAIL mrst_restart_data_errs got %0d want 0", c_derr); else passed++;
  endtask

`ifdef CACHE_WR_READY_EN
  task automatic test_wready();
    launch(32'h21, pageB);
    collect(pageB, 32'h21, 0, 0, 1);
    total++; if (c_nwr !== 128) $display("FAIL rdy_nwrites got %0d want 128", c_nwr); else passed++;
    total++; if (c_derr !== 0) $display("FAIL rdy_data_errs got %0d want 0", c_derr); else passed++;
    total++; if (c_stallerr !== 0) $display("FAIL rdy_stall_errs got %0d want 0", c_stallerr); else passed++;
    total++; if (c_lastacc !== 256) $display("FAIL rdy_last got %0d want 256", c_lastacc); else passed++;
    total++; if (c_end !== c_lastacc + 1) $display("FAIL rdy_end_at got %0d want %0d", c_end, c_lastacc + 1); else passed++;
  endtask
`endif

  initial begin
    for (int i = 0; i < WORDS; i++) begin
      pageA[i*WORD_W +: WORD_W] = 32'hA5000000 | 32'(i);
      pageB[i*WORD_W +: WORD_W] = 32'h5A5A0000 | 32'(i * 3 + 7);
    end
    test_reset();
    test_basic();
    test_input_change();
    test_pulse();
    test_done_hold();
    test_mid_reset();
`ifdef CACHE_WR_READY_EN
    test_wready();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
